// File: rtl/scan_controller.sv
// Scan capture controller: fills a sample buffer, hands it to the host or flushes it, and toggles between two buffers.
// Optional IDLE dwell timer before auto-flush is built only when SCANNER_IDLE_TIMEOUT_EN is defined.
module scan_controller #(
    parameter int DEPTH        = 100,
    parameter int READY_LVL    = 80,
    parameter int SECOND_LVL   = 90,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_scan,
    input  logic                       go_to_standby,
    input  logic                       transfer,
    input  logic                       sample_valid,
    output logic [2:0]                 state,
    output logic [$clog2(DEPTH+1)-1:0] data_count,
    output logic                       ready_to_transfer,
    output logic                       start_second_buffer,
    output logic                       flush_buffer,
    output logic                       active_buf,
    output logic                       overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] READY_C  = CW'(READY_LVL);
    localparam logic [CW-1:0] SECOND_C = CW'(SECOND_LVL);

    typedef enum logic [2:0] {
        LOW_POWER = 3'd0,
        ACTIVE    = 3'd1,
        STANDBY   = 3'd2,
        IDLE      = 3'd3,
        FLUSH     = 3'd4,
        TRANSFER  = 3'd5
    } state_t;

    if (DEPTH < 2 || DEPTH > 1023 || READY_LVL >= DEPTH || SECOND_LVL >= DEPTH ||
        IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_cfg
        $error("scan_controller: illegal parameter combination");
    end

    // Kept as raw bits so the unused codes 6-7 are representable and recoverable.
    logic [2:0]    st_q, st_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          buf_q, buf_tog;
    logic          ovf_q, ovf_nxt;

`ifdef SCANNER_IDLE_TIMEOUT_EN
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_C = TW'(IDLE_TIMEOUT - 1);
    logic [TW-1:0] tmr_q, tmr_nxt;
`endif

    always_comb begin
        st_nxt  = st_q;
        cnt_nxt = cnt_q;
        buf_tog = 1'b0;
`ifdef SCANNER_IDLE_TIMEOUT_EN
        tmr_nxt = '0;   // timer only runs while dwelling in IDLE
`endif
        case (st_q)
            LOW_POWER: begin
                if (start_scan)         st_nxt = ACTIVE;
                else if (go_to_standby) st_nxt = STANDBY;
            end
            STANDBY: begin
                if (start_scan) st_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (sample_valid && cnt_q < DEPTH_C) begin
                    cnt_nxt = cnt_q + 1'b1;
                    if (cnt_q == LAST_C) st_nxt = transfer ? TRANSFER : IDLE;
                end
            end
            IDLE: begin
                if (transfer) begin
                    st_nxt = TRANSFER;
                end else begin
`ifdef SCANNER_IDLE_TIMEOUT_EN
                    if (tmr_q == TMO_C) begin
                        st_nxt  = FLUSH;
                        cnt_nxt = '0;
                    end else begin
                        tmr_nxt = tmr_q + 1'b1;
                    end
`else
                    st_nxt  = FLUSH;
                    cnt_nxt = '0;
`endif
                end
            end
            FLUSH: begin
                st_nxt  = LOW_POWER;
                cnt_nxt = '0;
                buf_tog = 1'b1;
            end
            TRANSFER: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_nxt = '0;
                    st_nxt  = LOW_POWER;
                    buf_tog = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: begin
                st_nxt  = LOW_POWER;
                cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        ovf_nxt = ovf_q;
        if (st_nxt == ACTIVE && st_q != ACTIVE)
            ovf_nxt = 1'b0;
        else if (sample_valid && (st_q == IDLE || st_q == TRANSFER))
            ovf_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= LOW_POWER;
            cnt_q <= '0;
            buf_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            st_q  <= st_nxt;
            cnt_q <= cnt_nxt;
            buf_q <= buf_q ^ buf_tog;
            ovf_q <= ovf_nxt;
        end
    end

`ifdef SCANNER_IDLE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr_q <= '0;
        else     tmr_q <= tmr_nxt;
    end
`endif

    assign state               = st_q;
    assign data_count          = cnt_q;
    assign active_buf          = buf_q;
    assign overflow            = ovf_q;
    assign flush_buffer        = (st_q == FLUSH);
    assign ready_to_transfer   = (st_q == ACTIVE || st_q == IDLE) && (cnt_q >= READY_C);
    assign start_second_buffer = (st_q == ACTIVE || st_q == IDLE) && (cnt_q >= SECOND_C);
endmodule

// File: doc/scan_controller.md
SCAN_CONTROLLER -- requirements
Module: scan_controller

Interface
REQ-001 Parameter DEPTH, 100: samples per buffer fill; legal range 2..1023.
REQ-002 Parameter READY_LVL, 80: fill level at which ready_to_transfer asserts; READY_LVL < DEPTH.
REQ-003 Parameter SECOND_LVL, 90: fill level at which start_second_buffer asserts; SECOND_LVL < DEPTH.
REQ-004 Parameter IDLE_TIMEOUT, 16: IDLE dwell cycles before auto-flush; legal range 1..65535.
REQ-005 clk  input  1  single clock; all flops rise-edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start_scan  input  1  request capture.
REQ-008 go_to_standby  input  1  request standby from low power.
REQ-009 transfer  input  1  host accepts buffer contents.
REQ-010 sample_valid  input  1  one sample offered this cycle.
REQ-011 state  output  3  current state encoding.
REQ-012 data_count  output  $clog2(DEPTH+1)  fill level of current buffer.
REQ-013 ready_to_transfer, start_second_buffer, flush_buffer, active_buf, overflow  output  1 each  status (see Function).

Function
REQ-014 States SHALL be LOW_POWER=0, ACTIVE=1, STANDBY=2, IDLE=3, FLUSH=4, TRANSFER=5; codes 6–7 SHALL return to LOW_POWER next cycle.
REQ-015 LOW_POWER: start_scan -> ACTIVE; else go_to_standby -> STANDBY; start_scan wins when both are asserted.
REQ-016 STANDBY: start_scan -> ACTIVE; otherwise hold.
REQ-017 ACTIVE: sample_valid SHALL increment data_count by 1 per cycle.
REQ-018 ACTIVE exit: the edge that takes data_count to DEPTH also moves state to TRANSFER if transfer=1 that cycle, else to IDLE.
REQ-019 IDLE: transfer -> TRANSFER; otherwise a dwell timer counts, and the timer reaching IDLE_TIMEOUT -> FLUSH; the timer clears on IDLE entry.
REQ-020 TRANSFER: data_count SHALL decrement by 1 per cycle regardless of inputs; the edge that takes it to 0 moves state to LOW_POWER and toggles active_buf.
REQ-021 FLUSH: one cycle only; flush_buffer=1 for exactly that cycle; data_count cleared to 0; active_buf toggles; next state LOW_POWER.
REQ-022 ready_to_transfer SHALL be 1 when state is ACTIVE or IDLE and data_count >= READY_LVL, else 0.
REQ-023 start_second_buffer SHALL be 1 when state is ACTIVE or IDLE and data_count >= SECOND_LVL, else 0.
REQ-024 overflow SHALL set (sticky) on sample_valid=1 while in IDLE or TRANSFER, and clear on the edge entering ACTIVE.
REQ-025 All outputs SHALL be registered or pure decodes of registered state/count; no input-to-output combinational path.
REQ-026 data_count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-027 rst=1 SHALL immediately force state=LOW_POWER, data_count=0, dwell timer=0, active_buf=0, overflow=0, flush_buffer=0, ready_to_transfer=0, start_second_buffer=0.
REQ-028 rst asserted mid-ACTIVE or mid-TRANSFER SHALL abandon the buffer without a flush_buffer pulse.
REQ-029 After rst deasserts, the first state change SHALL occur on the next clk rising edge.

Configuration
REQ-030 Macro SCANNER_IDLE_TIMEOUT_EN defined: IDLE behaves per REQ-019.
REQ-031 Macro SCANNER_IDLE_TIMEOUT_EN undefined: IDLE without transfer SHALL go to FLUSH after one cycle, IDLE_TIMEOUT is ignored, and no dwell timer is built.

Verification (DEPTH=8, READY_LVL=6, SECOND_LVL=7, IDLE_TIMEOUT=4, macro defined unless noted)
REQ-032 start_scan pulse, then 8 cycles sample_valid with transfer=1 on the 8th -> ready_to_transfer at count 6, start_second_buffer at count 7, state 5, count 8->0 over 8 cycles, then state 0, active_buf=1.
REQ-033 Fill to 8 with transfer=0, no transfer for 4 cycles -> state 3 for 4 cycles, then state 4 with flush_buffer high for 1 cycle, count 0, then state 0.
REQ-034 Same as REQ-033 with the macro undefined -> state 3 for 1 cycle, then state 4.
REQ-035 start_scan and go_to_standby asserted together in LOW_POWER -> state 1; go_to_standby alone -> state 2, which holds until start_scan.
REQ-036 sample_valid during IDLE -> overflow=1, held until next ACTIVE entry.
REQ-037 rst asserted at count 5 in ACTIVE -> state 0 and count 0 asynchronously, with no flush_buffer pulse.
